// File: rtl/m_cp0.sv
// Coprocessor 0 for the M stage: exception/interrupt decision plus the
// SR, Cause, EPC and PRId registers, with the fetch redirect request.
module m_cp0 #(
    parameter logic [31:0] PRID = 32'h0000_7007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PCM,
    input  logic [4:0]  ExcCodeM,
    input  logic        BDM,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req = (|(HWInt & im)) & ie & ~exl;
    assign exc_req = (ExcCodeM != 5'd0) & ~exl;
    assign Req     = int_req | exc_req;

    // A faulting delay-slot instruction restarts at its branch; the subtract wraps at 0.
    assign pc_aligned = {PCM[31:2], 2'b00};
    assign epc_next   = BDM ? (pc_aligned - 32'd4) : pc_aligned;

    assign sr_word    = {16'b0, im, 8'b0, exl, ie};
    assign cause_word = {bd, 15'b0, ip, 3'b0, exc_code, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                // Taking the trap discards any mtc0 and eret in the same cycle.
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : ExcCodeM;
                bd       <= BDM;
                epc      <= epc_next;
            end else begin
                if (WE && A == 5'd12) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end
                if (WE && A == 5'd14) begin
                    epc <= {DIn[31:2], 2'b00};
                end
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (A)
            5'd12:   DOut = sr_word;
            5'd13:   DOut = cause_word;
            5'd14:   DOut = epc;
            5'd15:   DOut = PRID;
            default: DOut = 32'd0;
        endcase
    end

    assign EPCOut = epc;

endmodule

// File: tb/tb_m_cp0.sv
// Directed bench for m_cp0: reset, exceptions, delay slots, interrupts,
// eret re-arming and mtc0/mfc0 access rules.
module tb_m_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PCM;
    logic [4:0]  ExcCodeM;
    logic        BDM;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    int vectors;
    int miscompares;

    m_cp0 dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .DIn      (DIn),
        .WE       (WE),
        .PCM      (PCM),
        .ExcCodeM (ExcCodeM),
        .BDM      (BDM),
        .EXLClr   (EXLClr),
        .HWInt    (HWInt),
        .DOut     (DOut),
        .EPCOut   (EPCOut),
        .Req      (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic readReg(input logic [4:0] addr);
        A = addr;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        A        = 5'd0;
        DIn      = 32'd0;
        WE       = 1'b0;
        PCM      = 32'h0000_3000;
        ExcCodeM = 5'd0;
        BDM      = 1'b0;
        EXLClr   = 1'b0;
        HWInt    = 6'd0;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        #1;

        readReg(5'd12); checkOutput("init_sr", DOut, 32'h0);
        readReg(5'd13); checkOutput("init_cause", DOut, 32'h0);
        checkOutput("init_req", {31'b0, Req}, 32'h0);

        // Get into EXL=1 with EPC=0x3004, then reset mid-operation
        ExcCodeM = 5'd8; PCM = 32'h0000_3004;
        #1; checkOutput("pre_exc_req", {31'b0, Req}, 32'h1);
        applyStimulus();
        ExcCodeM = 5'd0;
        #1; checkOutput("pre_epc", EPCOut, 32'h0000_3004);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        readReg(5'd12); checkOutput("rst_sr", DOut, 32'h0);
        readReg(5'd13); checkOutput("rst_cause", DOut, 32'h0);
        readReg(5'd14); checkOutput("rst_epc_dout", DOut, 32'h0);
        checkOutput("rst_epcout", EPCOut, 32'h0);
        checkOutput("rst_req", {31'b0, Req}, 32'h0);

        // Overflow exception outside a delay slot
        ExcCodeM = 5'd12; PCM = 32'h0000_3008; BDM = 1'b0;
        #1; checkOutput("ov_req", {31'b0, Req}, 32'h1);
        applyStimulus();
        ExcCodeM = 5'd0;
        readReg(5'd13); checkOutput("ov_cause", DOut, 32'h0000_0030);
        checkOutput("ov_epc", EPCOut, 32'h0000_3008);
        readReg(5'd12); checkOutput("ov_sr", DOut, 32'h0000_0002);
        ExcCodeM = 5'd4;
        #1; checkOutput("masked_exc_req", {31'b0, Req}, 32'h0);
        ExcCodeM = 5'd0; EXLClr = 1'b1;
        applyStimulus();
        EXLClr = 1'b0;
        readReg(5'd12); checkOutput("eret_sr", DOut, 32'h0);

        // AdES in a delay slot
        ExcCodeM = 5'd5; PCM = 32'h0000_3010; BDM = 1'b1;
        applyStimulus();
        ExcCodeM = 5'd0; BDM = 1'b0;
        checkOutput("bd_epc", EPCOut, 32'h0000_300C);
        readReg(5'd13); checkOutput("bd_cause", DOut, 32'h8000_0014);
        EXLClr = 1'b1;
        applyStimulus();
        EXLClr = 1'b0;

        // EPC subtract wraps below zero
        ExcCodeM = 5'd4; PCM = 32'h0000_0000; BDM = 1'b1;
        applyStimulus();
        ExcCodeM = 5'd0; BDM = 1'b0;
        checkOutput("wrap_epc", EPCOut, 32'hFFFF_FFFC);
        EXLClr = 1'b1;
        applyStimulus();
        EXLClr = 1'b0;

        // Interrupt beats a simultaneous exception and drops the mtc0
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_0401;
        applyStimulus();
        WE = 1'b0;
        readReg(5'd12); checkOutput("int_sr_written", DOut, 32'h0000_0401);
        HWInt = 6'b000001; ExcCodeM = 5'd10; PCM = 32'h0000_3020;
        WE = 1'b1; A = 5'd14; DIn = 32'h1234_5678;
        #1; checkOutput("int_req", {31'b0, Req}, 32'h1);
        applyStimulus();
        WE = 1'b0; ExcCodeM = 5'd0;
        readReg(5'd13); checkOutput("int_cause", DOut, 32'h0000_0400);
        checkOutput("int_epc", EPCOut, 32'h0000_3020);
        readReg(5'd12); checkOutput("int_sr", DOut, 32'h0000_0403);
        checkOutput("int_masked_req", {31'b0, Req}, 32'h0);

        // eret with interrupt still pending re-raises Req next cycle
        EXLClr = 1'b1;
        applyStimulus();
        EXLClr = 1'b0;
        readReg(5'd12); checkOutput("eret2_sr", DOut, 32'h0000_0401);
        checkOutput("eret2_req", {31'b0, Req}, 32'h1);
        HWInt = 6'd0;
        #1; checkOutput("int_drop_req", {31'b0, Req}, 32'h0);

        // mtc0/mfc0 field masking and read-only registers
        WE = 1'b1; A = 5'd12; DIn = 32'hFFFF_FFFF;
        applyStimulus();
        WE = 1'b0;
        readReg(5'd12); checkOutput("sr_mask", DOut, 32'h0000_FC03);
        WE = 1'b1; A = 5'd13; DIn = 32'hFFFF_FFFF;
        applyStimulus();
        WE = 1'b0;
        readReg(5'd13); checkOutput("cause_ro", DOut, 32'h0);
        readReg(5'd15); checkOutput("prid", DOut, 32'h0000_7007);
        readReg(5'd7);  checkOutput("unmapped", DOut, 32'h0);

        // EPC write has no same-cycle bypass
        WE = 1'b1; A = 5'd14; DIn = 32'h0000_ABCD;
        #1; checkOutput("epc_nobypass_dout", DOut, 32'h0000_3020);
        checkOutput("epc_nobypass_out", EPCOut, 32'h0000_3020);
        applyStimulus();
        WE = 1'b0;
        checkOutput("epc_written", EPCOut, 32'h0000_ABCC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
